// File: rtl/mmu_requant.sv
// Requantisation stage behind the MMU: accumulates K partial-sum tiles popped from the
// result FIFO, then applies optional ReLU, arithmetic shift and int8 saturation.
module mmu_requant #(
  parameter int SIZE = 2,
  parameter int K_W  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [SIZE-1:0][SIZE-1:0][31:0]    acc_in,
  input  logic                               acc_in_rdy,
  output logic                               acc_in_pop,
  input  logic                               start,
  input  logic [K_W-1:0]                     k_tiles,
  input  logic [4:0]                         shift,
  input  logic                               relu_en,
  output logic                               busy,
  output logic                               done,
  output logic [SIZE-1:0][SIZE-1:0][7:0]     q_out,
  output logic                               q_valid,
  input  logic                               q_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_QUANT = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                            state_q, state_d;
  logic [SIZE-1:0][SIZE-1:0][31:0]   acc_q, acc_d;
  logic [K_W-1:0]                    cnt_q, cnt_d;
  logic [K_W-1:0]                    k_lat_q, k_lat_d;
  logic [4:0]                        shift_q, shift_d;
  logic                              relu_q, relu_d;
  logic [SIZE-1:0][SIZE-1:0][7:0]    q_out_q, q_out_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              q_valid_q, q_valid_d;

  // ReLU, arithmetic shift (rounds toward -inf) and saturation to int8.
  function automatic logic [7:0] requant(input logic [31:0] a, input logic [4:0] sh,
                                         input logic relu);
    logic signed [31:0] v;
    logic signed [31:0] s;
    logic [7:0]         r;
    v = (relu && a[31]) ? 32'sd0 : $signed(a);
    s = v >>> sh;
    if (s > 32'sd127) begin
      r = 8'h7f;
    end else if (s < -32'sd128) begin
      r = 8'h80;
    end else begin
      r = s[7:0];
    end
    return r;
  endfunction

  // The FIFO pop is combinational so a ready FIFO is drained in the same POP cycle.
  assign acc_in_pop = (state_q == S_POP) && acc_in_rdy;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_lat_d = k_lat_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    q_out_d = q_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_lat_d = (k_tiles == {K_W{1'b0}}) ? {{(K_W-1){1'b0}}, 1'b1} : k_tiles;
          shift_d = shift;
          relu_d  = relu_en;
          acc_d   = '0;
          cnt_d   = {K_W{1'b0}};
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        if (acc_in_rdy) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_POP;
        end
      end
      S_WAIT: state_d = S_ACC;
      S_ACC: begin
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE; j++) begin
            acc_d[i][j] = acc_q[i][j] + acc_in[i][j];
          end
        end
        cnt_d = cnt_q + {{(K_W-1){1'b0}}, 1'b1};
        if (cnt_d == k_lat_q) begin
          state_d = S_QUANT;
        end else begin
          state_d = S_POP;
        end
      end
      S_QUANT: begin
        for (int i = 0; i < SIZE; i++) begin
          for (int j = 0; j < SIZE; j++) begin
            q_out_d[i][j] = requant(acc_q[i][j], shift_q, relu_q);
          end
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (q_ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    q_valid_d = (state_d == S_OUT);
  end

  // State and output registers; reset drops any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= {K_W{1'b0}};
      k_lat_q   <= {K_W{1'b0}};
      shift_q   <= 5'd0;
      relu_q    <= 1'b0;
      q_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      k_lat_q   <= k_lat_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      q_out_q   <= q_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign q_valid = q_valid_q;
  assign q_out   = q_out_q;

endmodule
